booth_divide: RTL and testbench

- Sequential signed integer divider; the inverse of the team's 8x8 Booth multiplier datapath.
- Takes a 16-bit signed dividend and an 8-bit signed divisor.
- Produces a 16-bit signed quotient and an 8-bit signed remainder using a restoring shift-subtract algorithm on magnitudes, one quotient bit per clock.
- Sits beside the multiplier in the arithmetic unit. A start/busy/done handshake lets a controller issue one division at a time.

---
 rtl/booth_divide_if.sv | 19 +
 rtl/booth_divide.sv | 87 ++++++++
 tb/tb_booth_divide.sv | 129 ++++++++++++
 3 files changed

// File: rtl/booth_divide_if.sv
// booth_divide_if: start/busy/done handshake and operand/result bus for booth_divide
interface booth_divide_if #(
   parameter int DIVIDEND_W = 16,
   parameter int DIVISOR_W  = 8
);
   logic                  start;
   logic [DIVIDEND_W-1:0] dividend;
   logic [DIVISOR_W-1:0]  divisor;
   logic [DIVIDEND_W-1:0] quotient;
   logic [DIVISOR_W-1:0]  remainder;
   logic                  busy;
   logic                  done;
   logic                  div_by_zero;
   logic                  overflow;
   modport master (output start, dividend, divisor,
                   input  quotient, remainder, busy, done, div_by_zero, overflow);
   modport slave  (input  start, dividend, divisor,
                   output quotient, remainder, busy, done, div_by_zero, overflow);
endinterface

// File: rtl/booth_divide.sv
// booth_divide: sequential signed restoring divider on magnitudes, one quotient bit per clock
module booth_divide #(
   parameter int DIVIDEND_W = 16,
   parameter int DIVISOR_W  = 8
) (
   input logic           clock,
   input logic           reset,
   booth_divide_if.slave bus
);
   localparam int CW = $clog2(DIVIDEND_W);
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
   state_t                state, next;
   logic [CW-1:0]         cnt;
   logic [DIVISOR_W:0]    part;
   logic [DIVIDEND_W-1:0] shq;
   logic [DIVISOR_W-1:0]  dmag;
   logic                  sign_q, sign_r, zero;
   logic [DIVIDEND_W-1:0] quotient;
   logic [DIVISOR_W-1:0]  remainder;
   logic                  done, div_by_zero, overflow;
   logic [DIVISOR_W+1:0]  shifted, diff;
   logic                  fits;
   // shq starts as |dividend| and fills with quotient bits as the dividend shifts out
   assign shifted = {part, shq[DIVIDEND_W-1]};
   assign diff    = shifted - {2'b0, dmag};
   assign fits    = !diff[DIVISOR_W+1];
   always_comb begin
      next = state;
      case (state)
         IDLE:    if (bus.start) next = (bus.divisor == '0) ? FIX : CALC;
         CALC:    if (cnt == CW'(DIVIDEND_W-1)) next = FIX;
         default: next = IDLE;
      endcase
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) state <= IDLE;
      else state <= next;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt         <= '0;
         part        <= '0;
         shq         <= '0;
         dmag        <= '0;
         sign_q      <= 1'b0;
         sign_r      <= 1'b0;
         zero        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               sign_q <= bus.dividend[DIVIDEND_W-1] ^ bus.divisor[DIVISOR_W-1];
               sign_r <= bus.dividend[DIVIDEND_W-1];
               shq    <= bus.dividend[DIVIDEND_W-1] ? -bus.dividend : bus.dividend;
               dmag   <= bus.divisor[DIVISOR_W-1] ? -bus.divisor : bus.divisor;
               zero   <= bus.divisor == '0;
               part   <= '0;
               cnt    <= '0;
            end
            CALC: begin
               part <= fits ? diff[DIVISOR_W:0] : shifted[DIVISOR_W:0];
               shq  <= {shq[DIVIDEND_W-2:0], fits};
               cnt  <= cnt + 1'b1;
            end
            FIX: begin
               done        <= 1'b1;
               div_by_zero <= zero;
               // only most-negative / -1 yields a positive magnitude with the MSB set
               overflow    <= !zero && !sign_q && shq[DIVIDEND_W-1];
               quotient    <= zero ? '0 : sign_q ? -shq : shq;
               remainder   <= zero ? '0 : sign_r ? -part[DIVISOR_W-1:0] : part[DIVISOR_W-1:0];
            end
            default: ;
         endcase
      end
   end
   assign bus.quotient    = quotient;
   assign bus.remainder   = remainder;
   assign bus.busy        = state != IDLE;
   assign bus.done        = done;
   assign bus.div_by_zero = div_by_zero;
   assign bus.overflow    = overflow;
endmodule

// File: tb/tb_booth_divide.sv
// tb_booth_divide: directed and random divisions checked against integer / and % arithmetic
module tb_booth_divide;
   logic clock = 1'b0;
   logic reset = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;
   booth_divide_if bus ();
   booth_divide dut (.clock(clock), .reset(reset), .bus(bus));
   always #5 clock = ~clock;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // called at a negedge; poke>=0 pulses an ignored 9/3 request that many cycles after acceptance
   task automatic run(input logic [15:0] a, input logic [7:0] b, input int poke);
      int ai, bi, qi, ri, lat, bc;
      logic [15:0] eq;
      logic [7:0]  er;
      logic        edz, eov;
      ai  = int'($signed(a));
      bi  = int'($signed(b));
      edz = bi == 0;
      eov = 1'b0;
      eq  = '0;
      er  = '0;
      if (!edz) begin
         qi  = ai / bi;
         ri  = ai % bi;
         eq  = qi[15:0];
         er  = ri[7:0];
         eov = qi > 32767;
      end
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      @(negedge clock);
      bus.start = 1'b0;
      lat = 0;
      bc  = 0;
      while (!bus.done && lat < 40) begin
         if (bus.busy) bc++;
         if (lat == poke) begin
            bus.start    = 1'b1;
            bus.dividend = 16'd9;
            bus.divisor  = 8'd3;
         end
         if (lat == poke + 1) bus.start = 1'b0;
         @(negedge clock);
         lat++;
      end
      check("latency", lat, edz ? 1 : 17);
      check("busy_cycles", bc, edz ? 1 : 17);
      check("busy_at_done", bus.busy, 0);
      check("quotient", bus.quotient, eq);
      check("remainder", bus.remainder, er);
      check("div_by_zero", bus.div_by_zero, edz);
      check("overflow", bus.overflow, eov);
      @(negedge clock);
      check("done_one_cycle", bus.done, 0);
      check("hold_quotient", bus.quotient, eq);
      check("hold_remainder", bus.remainder, er);
   endtask
   initial begin
      int seen;
      logic [15:0] a;
      logic [7:0]  b;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      #2 reset = 1'b1;
      repeat (2) @(negedge clock);
      check("rst_quotient", bus.quotient, 0);
      check("rst_remainder", bus.remainder, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_flags", {bus.div_by_zero, bus.overflow}, 0);
      reset = 1'b0;
      @(negedge clock);
      run(16'd100, 8'd7, -1);
      run(-16'sd100, 8'd7, -1);
      run(16'd1000, -8'sd3, -1);
      run(16'h8000, 8'hFF, -1);
      run(16'h8000, 8'h80, -1);
      run(16'd1234, 8'd0, -1);
      run(16'd0, 8'd5, -1);
      run(16'd50, 8'd5, 5);
      run(16'd9, 8'd3, -1);
      run(16'h7FFF, 8'h80, -1);
      run(16'h8000, 8'h01, -1);
      run(16'd100, 8'd7, -1);
      bus.start    = 1'b1;
      bus.dividend = 16'd100;
      bus.divisor  = 8'd7;
      @(negedge clock);
      bus.start = 1'b0;
      repeat (7) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      check("abort_quotient", bus.quotient, 0);
      check("abort_remainder", bus.remainder, 0);
      check("abort_busy", bus.busy, 0);
      @(negedge clock);
      reset = 1'b0;
      seen = 0;
      repeat (25) begin
         @(negedge clock);
         if (bus.done) seen++;
      end
      check("abort_no_done", seen, 0);
      run(16'd100, 8'd7, -1);
      for (int i = 0; i < 40; i++) begin
         a = 16'($urandom);
         b = 8'($urandom);
         case ($urandom_range(0, 9))
            0: b = 8'h00;
            1: b = 8'hFF;
            2: a = 16'h8000;
            3: b = 8'h80;
            default: ;
         endcase
         run(a, b, -1);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
